// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the round-robin request arbiter.
// Requester count is fixed at 8 for this revision, so the grant index is 3 bits wide.
package rr_arb_pkg;

   localparam int N   = 8;
   localparam int IDW = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotated lowest-set-bit priority search; req bit ptr has top priority.
// Purely combinational, zero latency; no flow control, winner is meaningless when any_req=0.
module rr_pick
   import rr_arb_pkg::*;
(
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [IDW-1:0] winner,
   output logic           any_req
);

   logic [N-1:0]   rot;
   logic [IDW-1:0] k;

   // Rotate right by ptr; the IDW-bit index sum wraps mod N on its own.
   always_comb begin
      rot = '0;
      for (int i = 0; i < N; i++) begin
         rot[i] = req[IDW'(i) + ptr];
      end
   end

   // Scan downwards so the lowest set bit is the last one written.
   always_comb begin
      k = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            k = IDW'(i);
         end
      end
   end

   assign winner  = ptr + k;
   assign any_req = |req;

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter: 8 requesters share one resource, registered one-hot grant.
// Latency: req in IDLE -> grant next cycle; release/limit -> grant drops next cycle.
// Backpressure: owner holds until done, req drop, or MAX_HOLD cycles; no preemption.
module rr_req_arbiter
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)
(
   input  logic           clk,
   input  logic           areset,
   input  logic [N-1:0]   req,
   input  logic           done,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid,
   output logic           timeout
);

   localparam int             HCW       = $clog2(MAX_HOLD);
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [HCW-1:0] hold_cnt;

   logic [IDW-1:0] winner;
   logic           any_req;
   logic [N-1:0]   win_onehot;
   logic           owner_req;
   logic           hold_hit;
   logic           end_grant;

   rr_pick u_pick (
      .req     (req),
      .ptr     (ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   assign win_onehot = N'(1) << winner;
   assign owner_req  = req[gnt_id];
   assign hold_hit   = (hold_cnt == HOLD_LAST);
   assign end_grant  = done | ~owner_req | hold_hit;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  state     <= GRANT;
                  gnt       <= win_onehot;
                  gnt_id    <= winner;
                  gnt_valid <= 1'b1;
                  hold_cnt  <= '0;
               end
            end
            GRANT: begin
               if (end_grant) begin
                  state     <= IDLE;
                  gnt       <= '0;
                  gnt_id    <= '0;
                  gnt_valid <= 1'b0;
                  ptr       <= gnt_id + IDW'(1);
                  hold_cnt  <= '0;
                  // Only flag a revoke the owner did not ask for.
                  timeout   <= ~done & owner_req;
               end else begin
                  hold_cnt <= hold_cnt + HCW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Bench for rr_req_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_rr_req_arbiter;

   localparam int MAXH = 16;

   logic       clk = 1'b0;
   logic       areset;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int errs = 0;
   int chks = 0;

   // behavioural model state
   bit m_busy;
   bit m_to;
   int m_id;
   int m_ptr;
   int m_hold;

   always #5 clk = ~clk;

   rr_req_arbiter #(.MAX_HOLD(MAXH)) dut (
      .clk       (clk),
      .areset    (areset),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   function automatic int pick(input logic [7:0] r, input int p);
      for (int j = 0; j < 8; j++) begin
         if (r[(p + j) % 8]) return (p + j) % 8;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0;
      m_to   = 1'b0;
      m_id   = 0;
      m_ptr  = 0;
      m_hold = 0;
   endtask

   task automatic model_edge(input logic [7:0] r, input logic d);
      m_to = 1'b0;
      if (!m_busy) begin
         if (r != 8'h00) begin
            m_busy = 1'b1;
            m_id   = pick(r, m_ptr);
            m_hold = 0;
         end
      end else if (d || !r[m_id] || m_hold == MAXH - 1) begin
         m_to   = !d && r[m_id];
         m_busy = 1'b0;
         m_ptr  = (m_id + 1) % 8;
         m_hold = 0;
      end else begin
         m_hold++;
      end
   endtask

   // Drive inputs away from the edge, advance one clock, land 1ns after the edge.
   task automatic step(input logic [7:0] r, input logic d);
      req  = r;
      done = d;
      @(posedge clk);
      model_edge(r, d);
      #1;
   endtask

   task automatic do_reset();
      req    = 8'h00;
      done   = 1'b0;
      areset = 1'b1;
      model_reset();
      #3;
      areset = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      req    = 8'h00;
      done   = 1'b0;
      model_reset();
      #3;
      chks++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== 13'h0) begin
         errs++;
         $display("FAIL reset_state: got %h want 0", {gnt, gnt_id, gnt_valid, timeout});
      end
      req    = 8'hFF;
      areset = 1'b0;
      step(8'hFF, 1'b0);
      chks++;
      if (gnt_id !== 3'd0 || gnt_valid !== 1'b1 || gnt !== 8'h01) begin
         errs++;
         $display("FAIL first_grant: got id=%0d vld=%b gnt=%h want id=0 vld=1 gnt=01", gnt_id, gnt_valid, gnt);
      end
      step(8'hFF, 1'b0);
      #2;
      areset = 1'b1;
      #1;
      chks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
         errs++;
         $display("FAIL async_reset: got gnt=%h vld=%b id=%0d want 00/0/0", gnt, gnt_valid, gnt_id);
      end
      model_reset();
      #1;
      areset = 1'b0;
      step(8'hFF, 1'b0);
      chks++;
      if (gnt_id !== 3'd0 || gnt_valid !== 1'b1) begin
         errs++;
         $display("FAIL grant_after_reset: got id=%0d vld=%b want id=0 vld=1", gnt_id, gnt_valid);
      end
   endtask

   task automatic test_priority();
      do_reset();
      step(8'b0001_0100, 1'b0);
      chks++;
      if (gnt !== 8'b0000_0100 || gnt_id !== 3'd2 || gnt_valid !== 1'b1 || timeout !== 1'b0) begin
         errs++;
         $display("FAIL priority: got gnt=%b id=%0d vld=%b to=%b want 00000100/2/1/0", gnt, gnt_id, gnt_valid, timeout);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step(8'hFF, 1'b0);
         chks++;
         if (gnt_valid !== 1'b1 || gnt_id !== 3'(i % 8)) begin
            errs++;
            $display("FAIL rr_grant[%0d]: got id=%0d vld=%b want id=%0d vld=1", i, gnt_id, gnt_valid, i % 8);
         end
         step(8'hFF, 1'b1);
         chks++;
         if (gnt_valid !== 1'b0 || gnt !== 8'h00 || timeout !== 1'b0) begin
            errs++;
            $display("FAIL rr_idle[%0d]: got vld=%b gnt=%h to=%b want 0/00/0", i, gnt_valid, gnt, timeout);
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      step(8'b0100_0000, 1'b0);
      step(8'b0100_0000, 1'b1);
      step(8'b0100_0001, 1'b0);
      chks++;
      if (gnt_id !== 3'd0 || gnt_valid !== 1'b1) begin
         errs++;
         $display("FAIL wrap_to_0: got id=%0d vld=%b want id=0 vld=1", gnt_id, gnt_valid);
      end
      step(8'b0100_0001, 1'b1);
      step(8'b0100_0001, 1'b0);
      chks++;
      if (gnt_id !== 3'd6 || gnt !== 8'b0100_0000) begin
         errs++;
         $display("FAIL wrap_next_6: got id=%0d gnt=%b want id=6 gnt=01000000", gnt_id, gnt);
      end
   endtask

   task automatic test_timeout();
      int cnt;
      int to_seen;
      do_reset();
      step(8'h08, 1'b0);
      cnt     = (gnt_valid === 1'b1) ? 1 : 0;
      to_seen = 0;
      for (int i = 0; i < 40; i++) begin
         step(8'h08, 1'b0);
         if (gnt_valid === 1'b1) begin
            cnt++;
            if (timeout !== 1'b0) to_seen++;
         end else begin
            break;
         end
      end
      chks++;
      if (cnt != MAXH || to_seen != 0) begin
         errs++;
         $display("FAIL hold_length: got %0d cycles (early timeouts %0d) want %0d", cnt, to_seen, MAXH);
      end
      chks++;
      if (timeout !== 1'b1 || gnt_valid !== 1'b0) begin
         errs++;
         $display("FAIL timeout_pulse: got to=%b vld=%b want to=1 vld=0", timeout, gnt_valid);
      end
      step(8'h08, 1'b0);
      chks++;
      if (timeout !== 1'b0 || gnt_valid !== 1'b1 || gnt_id !== 3'd3) begin
         errs++;
         $display("FAIL regrant: got to=%b vld=%b id=%0d want 0/1/3", timeout, gnt_valid, gnt_id);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      step(8'h08, 1'b0);
      for (int i = 0; i < MAXH - 1; i++) step(8'h08, 1'b0);
      step(8'h08, 1'b1);
      chks++;
      if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
         errs++;
         $display("FAIL done_at_limit: got vld=%b to=%b want 0/0", gnt_valid, timeout);
      end
      step(8'h00, 1'b1);
      chks++;
      if (gnt_valid !== 1'b0 || gnt !== 8'h00) begin
         errs++;
         $display("FAIL done_in_idle: got vld=%b gnt=%h want 0/00", gnt_valid, gnt);
      end
      step(8'h08, 1'b1);
      chks++;
      if (gnt_valid !== 1'b1 || gnt_id !== 3'd3) begin
         errs++;
         $display("FAIL grant_despite_done: got vld=%b id=%0d want 1/3", gnt_valid, gnt_id);
      end
   endtask

   task automatic test_req_drop();
      do_reset();
      step(8'b0010_0000, 1'b0);
      chks++;
      if (gnt_id !== 3'd5 || gnt_valid !== 1'b1) begin
         errs++;
         $display("FAIL owner5: got id=%0d vld=%b want 5/1", gnt_id, gnt_valid);
      end
      step(8'h00, 1'b0);
      chks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
         errs++;
         $display("FAIL req_drop: got gnt=%h vld=%b to=%b want 00/0/0", gnt, gnt_valid, timeout);
      end
      step(8'hFF, 1'b0);
      chks++;
      if (gnt_id !== 3'd6) begin
         errs++;
         $display("FAIL ptr_after_drop: got id=%0d want 6", gnt_id);
      end
   endtask

   task automatic test_random();
      logic [7:0] r;
      logic       d;
      logic [7:0] eg;
      logic [2:0] ei;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         r = 8'($urandom);
         if ($urandom_range(0, 1) == 0) r = r & 8'($urandom);
         if (m_busy && $urandom_range(0, 9) != 0) r[m_id] = 1'b1;
         d = ($urandom_range(0, 11) == 0);
         step(r, d);
         eg = m_busy ? (8'h01 << m_id) : 8'h00;
         ei = m_busy ? 3'(m_id) : 3'd0;
         chks++;
         if ({gnt, gnt_id, gnt_valid, timeout} !== {eg, ei, m_busy, m_to}) begin
            errs++;
            $display("FAIL random[%0d]: got gnt=%h id=%0d vld=%b to=%b want gnt=%h id=%0d vld=%b to=%b",
                     c, gnt, gnt_id, gnt_valid, timeout, eg, ei, m_busy, m_to);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_priority();
      test_round_robin();
      test_wrap();
      test_timeout();
      test_simultaneous();
      test_req_drop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

endmodule
